// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Oversamples the gated serial stream from the phase-detector serializer on
//   the local clock, reassembles MSB-first words, and presents them on a
//   valid/ready holding register with frame-error and overflow status.
//
// Ports
//   clk, rst       sampling clock (>=4x bit rate), synchronous active-high reset
//   serial_clk     async gated bit clock, high during first half of each bit
//   serial_out     async data, changes on rising serial_clk
//   serial_valid   async, high for serial_size bit periods per word
//   word_data      received word (held while word_valid && !word_ready)
//   phase_count    upper phase_count_size bits of word_data
//   clock_count    remaining lower bits of word_data
//   word_valid     holding register full
//   word_ready     consumer handshake
//   frame_error    one-cycle pulse per discarded partial word
//   overflow       sticky; a completed word found the holding register full
//   word_count     words loaded into the holding register (wraps)
//   error_count    frame errors (saturates at 255)
module serial_word_receiver #(
  parameter int serial_size      = 8,
  parameter int phase_count_size = 5,
  parameter int sync_stages      = 2,
  parameter int count_width      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  serial_clk,
  input  logic                                  serial_out,
  input  logic                                  serial_valid,
  output logic [serial_size-1:0]                word_data,
  output logic [phase_count_size-1:0]           phase_count,
  output logic [serial_size-phase_count_size-1:0] clock_count,
  output logic                                  word_valid,
  input  logic                                  word_ready,
  output logic                                  frame_error,
  output logic                                  overflow,
  output logic [count_width-1:0]                word_count,
  output logic [7:0]                            error_count
);

  localparam int BW = $clog2(serial_size + 1);

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_RECV      = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [sync_stages-1:0] sclk_sync_q, sdat_sync_q, svld_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, sdat_s, svld_s;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      sdat_sync_q <= '0;
      svld_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[sync_stages-2:0], serial_clk};
      sdat_sync_q <= {sdat_sync_q[sync_stages-2:0], serial_out};
      svld_sync_q <= {svld_sync_q[sync_stages-2:0], serial_valid};
      sclk_dly_q  <= sclk_sync_q[sync_stages-1];
    end
  end

  assign sclk_s = sclk_sync_q[sync_stages-1];
  assign sdat_s = sdat_sync_q[sync_stages-1];
  assign svld_s = svld_sync_q[sync_stages-1];
  // Falling serial_clk lands mid-bit, where data is settled.
  assign fall   = sclk_dly_q & ~sclk_s;

  // ---------------------------------------------------------------------------
  // Sample stage: registers the mid-bit strobe with its data/valid so the FSM
  // works from flops only. fill_q marks when the sampled valid reflects the
  // real input rather than the cleared synchronizer, so a reset released
  // mid-word cannot mistake the flushed pipeline for an idle line.
  // ---------------------------------------------------------------------------
  logic                 fall_q, bit_q, vld_q;
  logic [sync_stages:0] fill_q;
  logic                 primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q <= 1'b0;
      bit_q  <= 1'b0;
      vld_q  <= 1'b0;
      fill_q <= '0;
    end else begin
      fall_q <= fall;
      bit_q  <= sdat_s;
      vld_q  <= svld_s;
      fill_q <= {fill_q[sync_stages-1:0], 1'b1};
    end
  end

  assign primed = fill_q[sync_stages];

  // ---------------------------------------------------------------------------
  // Word assembly FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [serial_size-1:0] shift_q, shift_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   complete, discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    complete  = 1'b0;
    discard   = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (primed && !vld_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (fall_q && vld_q) begin
          shift_d   = {shift_q[serial_size-2:0], bit_q};
          bit_cnt_d = BW'(1);
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        if (!vld_q) begin
          discard   = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (fall_q) begin
          shift_d = {shift_q[serial_size-2:0], bit_q};
          if (bit_cnt_q == BW'(serial_size - 1)) begin
            complete  = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register and status
  // ---------------------------------------------------------------------------
  logic [serial_size-1:0] word_data_q;
  logic                   word_valid_q, frame_error_q, overflow_q;
  logic [count_width-1:0] word_count_q;
  logic [7:0]             error_count_q;
  logic                   load;

  // A word may enter when the register is empty or drains this same cycle.
  assign load = complete & (~word_valid_q | word_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      word_data_q   <= '0;
      word_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
      word_count_q  <= '0;
      error_count_q <= '0;
    end else begin
      frame_error_q <= discard;
      if (discard && error_count_q != 8'hFF)
        error_count_q <= error_count_q + 8'd1;
      if (load) begin
        word_data_q  <= shift_d;
        word_valid_q <= 1'b1;
        word_count_q <= word_count_q + count_width'(1);
      end else if (word_ready) begin
        word_valid_q <= 1'b0;
      end
      if (complete && !load) overflow_q <= 1'b1;
    end
  end

  assign word_data   = word_data_q;
  assign phase_count = word_data_q[serial_size-1 -: phase_count_size];
  assign clock_count = word_data_q[serial_size-phase_count_size-1:0];
  assign word_valid  = word_valid_q;
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;
  assign word_count  = word_count_q;
  assign error_count = error_count_q;

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Receives the gated serial stream produced by the phase-detector serializer (`serial_clk`, `serial_out`, `serial_valid`; 8-bit words, MSB first), oversampling it on a single local clock. Reassembles each word and splits it into its phase-count and clock-count fields. Presents each word on a valid/ready interface, with error and overflow status. Sits directly downstream of the serializer, on the capture/readout board.

## Interface
Parameters:
- `serial_size`, 8, bits per word
- `phase_count_size`, 5, width of the phase field in word bits [serial_size-1 : serial_size-phase_count_size]
- `sync_stages`, 2, synchronizer depth applied to all three serial inputs (≥2)
- `count_width`, 16, width of `word_count`

Ports:
- `clk`  in  1  sampling clock; must be ≥4× the serial bit rate
- `rst`  in  1  synchronous, active-high reset
- `serial_clk`  in  1  asynchronous; gated bit clock, high during the first half of each bit
- `serial_out`  in  1  asynchronous; data, changes on the rising edge of `serial_clk`
- `serial_valid`  in  1  asynchronous; high for exactly `serial_size` bit periods per word
- `word_data`  out  serial_size  received word
- `phase_count`  out  phase_count_size  `word_data` upper field
- `clock_count`  out  serial_size-phase_count_size  `word_data` lower field
- `word_valid`  out  1  holding register full
- `word_ready`  in  1  consumer accepts the word when `word_valid` and `word_ready` are both high
- `frame_error`  out  1  one-cycle pulse when a partial word is discarded
- `overflow`  out  1  sticky; a completed word was dropped
- `word_count`  out  count_width  words accepted into the holding register; wraps
- `error_count`  out  8  frame errors; saturates at 255

## Operation
- All three inputs pass through `sync_stages` flops, then one delay flop. `fall` = delayed `serial_clk` high AND synchronized `serial_clk` low. Data and valid are sampled from the synchronized copies in the `fall` cycle, which is mid-bit.
- FSM states:
  - WAIT_IDLE (reset state): stays until synchronized `serial_valid` is low for 1 cycle, then goes to IDLE. This guarantees the receiver never joins mid-word.
  - IDLE: on `fall` with valid high, shifts the bit in, sets `bit_cnt`=1 and goes to RECV. A `fall` with valid low is ignored.
  - RECV: on `fall` with valid high, shifts the bit in (left shift, LSB in) and increments `bit_cnt`. When `bit_cnt` reaches `serial_size`, the word is complete: the block attempts a load, clears `bit_cnt` and goes to IDLE. If synchronized valid is low (with or without `fall`), the partial word is discarded: `frame_error` pulses, `error_count` increments (saturating) and the FSM goes to IDLE.
- Load rules:
  - If the holding register is empty, or is being drained in the same cycle (`word_valid` & `word_ready`), `word_data` is loaded, `word_valid` is set and `word_count` increments (mod 2^count_width).
  - Otherwise the new word is dropped, `overflow` is set and `word_count` is unchanged.
- `word_valid` clears on handshake unless a load happens in the same cycle.
- `phase_count` and `clock_count` are pure slices of `word_data`.

## Timing
- Reset values: `word_data`=0, `word_valid`=0, `frame_error`=0, `overflow`=0, `word_count`=0, `error_count`=0; FSM=WAIT_IDLE; synchronizers cleared. A reset mid-word discards the partial word with no `frame_error`.
- Latency: `word_valid` rises `sync_stages`+2 clk cycles after the `clk` edge that first sees the final falling edge of `serial_clk` (±1 cycle from asynchronous capture).
- `word_data` and the field outputs are stable while `word_valid` is high and unacknowledged.
- `frame_error` is high for exactly one cycle per discarded word.
- `overflow` clears only on `rst`.
- Back-to-back words with a gap of 1 bit period or more are received without loss while `word_ready` is high.

## Test plan
- Single word 0xA5 at clk/8 bit rate, `word_ready`=1 -> one `word_valid` pulse with `word_data`=0xA5, `phase_count`=0x14, `clock_count`=0x5, `word_count`=1.
- Words 0x00, 0xFF, 0x3C back to back (1-bit-period gaps), `word_ready`=1 -> the same three words in order, `word_count`=3, `overflow`=0.
- `word_ready`=0, send 0x11 then 0x22 -> `word_data` holds 0x11, `overflow`=1, `word_count`=1. Raise `word_ready` -> `word_valid` drops, 0x22 is never presented.
- `serial_valid` dropped after 5 bits, then a full word 0x81 -> one `frame_error` pulse, `error_count`=1, then 0x81 received correctly.
- `rst` released while a word is mid-transmission, then a full word 0x7E -> partial word ignored, no `frame_error`, first output is 0x7E. Separately, 300 frame errors -> `error_count`=255.
